mc6809e_bus_responder: RTL
==========================

Name: mc6809e_bus_responder

Overview:
- Target-side companion to the 6809E CPU wrapper.
- Generates the E/Q quadrature clocks the 6809E needs from one fast system clock.
- Decodes one address window, responds to CPU reads and writes on that window, and passes each access to a synchronous backend through a REQ/ACK handshake.
- Holds E high (clock stretch) until the backend acknowledges, so slow System86 resources (shared RAM, ROM loaders) can serve the CPU without wait-state logic in the core.

Parameters:
- DIV, 3, CLK cycles per E/Q quarter-phase (≥1); one bus cycle = 4*DIV CLKs unstretched
- ADDR_BASE, 16'h0000, window base address
- ADDR_MASK, 16'hE000, address bits compared; hit = ((A & ADDR_MASK) == (ADDR_BASE & ADDR_MASK))
- STRETCH_MAX, 16, maximum extra CLKs E may be held high awaiting ACK

Ports:
- CLK  in  1  system clock
- nRESET  in  1  asynchronous, active-low reset
- E  out  1  6809E E clock
- Q  out  1  6809E Q clock (leads E by one quarter)
- A  in  16  CPU address
- RnW  in  1  CPU read/not-write
- DIn  in  8  CPU data bus (write data)
- DOut  out  8  read data to CPU
- DOE  out  1  DOut drive enable; top level tristates D with it
- SEL  out  1  current bus cycle hits the window
- REQ  out  1  backend request, level, held until ACK or timeout
- REQ_WE  out  1  1 = write request
- REQ_ADDR  out  16  latched address
- REQ_WDATA  out  8  latched write data
- ACK  in  1  backend completion, single-CLK pulse
- RDATA  in  8  backend read data, valid with ACK
- TIMEOUT  out  1  one-CLK pulse when stretch limit expires

Behaviour:
- Reset (asynchronous): E=0, Q=0, phase=P0, quarter counter=0, stretch counter=0. Outputs SEL, REQ, REQ_WE, DOE, TIMEOUT = 0; REQ_ADDR = 0; REQ_WDATA = 0; DOut = 8'hFF.
- Reset mid-stretch abandons the access immediately: REQ drops, no ACK is awaited. After release the first phase is P0.
- Phase machine advances after DIV CLKs per phase:
  - P0: E=0, Q=0
  - P1: E=0, Q=1
  - P2: E=1, Q=1
  - P3: E=1, Q=0
  - P3 → P0 only if DIV CLKs have elapsed AND no access is pending.
- Decode: on the last CLK of P1, latch A into REQ_ADDR and RnW into REQ_WE = ~RnW, and evaluate hit. SEL = hit from P2 entry until P0 entry.
- Read hit:
  - REQ=1 from the first CLK of P2.
  - On ACK: latch RDATA into DOut and drop REQ on the next CLK.
  - DOE=1 from the first CLK after ACK until P0 entry.
- Write hit:
  - Latch DIn into REQ_WDATA on the last CLK of P2.
  - REQ=1 from the first CLK of P3; ACK drops it. DOE stays 0.
- ACK is accepted in the same CLK that REQ first rises. ACK while REQ=0 is ignored. RDATA is ignored on writes.
- Stretch: while in P3 with DIV elapsed and REQ=1, stay in P3 (E held high).
  - Stretch counter increments each stretched CLK.
  - When the counter reaches STRETCH_MAX: drop REQ, pulse TIMEOUT for one CLK, force DOut=8'hFF (reads, with DOE=1), then go to P0 next CLK.
- Non-hit cycles never stretch; SEL, REQ and DOE stay 0.
- Only one access per bus cycle. The stretch counter clears on P0 entry.

Optional Feature:
- Macro MC6809E_BUS_STRETCH_EN.
- Defined: stretching as described above.
- Undefined: E is never held. P3 always lasts exactly DIV CLKs. If REQ is still 1 on the last CLK of P3: drop REQ, pulse TIMEOUT, read returns 8'hFF. STRETCH_MAX is unused.

Test Plan (DIV=2, ADDR_BASE=16'h2000, ADDR_MASK=16'hE000, STRETCH_MAX=16, macro defined unless stated):
- Free run after reset, no CPU activity → E/Q period 8 CLKs, Q rises 2 CLKs before E, SEL=0, no REQ.
- Read A=16'h2345, ACK with RDATA=8'h5A in the first P2 CLK → REQ_ADDR=16'h2345, DOE=1, DOut=8'h5A before E falls, no stretch (period 8).
- Write A=16'h3FFF, DIn=8'hC3, ACK 5 CLKs after REQ → REQ_WE=1, REQ_WDATA=8'hC3, E high 4 CLKs longer than nominal, then P0.
- Read A=16'h2000, never ACK → E high for STRETCH_MAX extra CLKs, TIMEOUT one pulse, DOut=8'hFF, REQ=0 after timeout.
- Access A=16'h4000 with ACK asserted spuriously → SEL=0, REQ=0, DOE=0, period 8.
- nRESET low during a stretched read → E=0, Q=0, REQ=0 immediately; after release first phase P0, then normal cycles. Repeat with macro undefined and ACK late → TIMEOUT at end of P3, no stretch.

Source files
------------

// File: rtl/mc6809e_bus_responder.sv
// rtl/mc6809e_bus_responder.sv - 6809E E/Q clock generator and windowed bus target with REQ/ACK backend
// Optional feature macro: MC6809E_BUS_STRETCH_EN (hold E high while the backend is busy).
module mc6809e_bus_responder #(
    parameter int unsigned DIV         = 3,
    parameter logic [15:0] ADDR_BASE   = 16'h0000,
    parameter logic [15:0] ADDR_MASK   = 16'hE000,
    parameter int unsigned STRETCH_MAX = 16
) (
    input  logic        CLK,
    input  logic        nRESET,
    output logic        E,
    output logic        Q,
    input  logic [15:0] A,
    input  logic        RnW,
    input  logic [7:0]  DIn,
    output logic [7:0]  DOut,
    output logic        DOE,
    output logic        SEL,
    output logic        REQ,
    output logic        REQ_WE,
    output logic [15:0] REQ_ADDR,
    output logic [7:0]  REQ_WDATA,
    input  logic        ACK,
    input  logic [7:0]  RDATA,
    output logic        TIMEOUT
);

`ifdef MC6809E_BUS_STRETCH_EN
    localparam bit STRETCH_EN = 1'b1;
`else
    localparam bit STRETCH_EN = 1'b0;
`endif

    localparam int unsigned QW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SW = $clog2(STRETCH_MAX + 2);

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_e;

    phase_e          phase_q, phase_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [SW-1:0]   stretch_q, stretch_d;
    logic            e_q, e_d;
    logic            q_q, q_d;
    logic            sel_q, sel_d;
    logic            req_q, req_d;
    logic            req_we_q, req_we_d;
    logic [15:0]     req_addr_q, req_addr_d;
    logic [7:0]      req_wdata_q, req_wdata_d;
    logic [7:0]      dout_q, dout_d;
    logic            doe_q, doe_d;
    logic            timeout_q, timeout_d;

    logic            last_clk;
    logic            hit;
    logic            ack_acc;
    logic            pending;
    logic [SW-1:0]   stretch_nxt;
    logic            smax;

    assign last_clk    = (qcnt_q == QW'(DIV - 1));
    assign hit         = ((A & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
    assign ack_acc     = req_q && ACK;
    // A write acked this CLK is finished; an acked read still needs one CLK to present DOut.
    assign pending     = req_q && !(ACK && req_we_q);
    assign stretch_nxt = stretch_q + SW'(1);
    assign smax        = (stretch_nxt >= SW'(STRETCH_MAX));

    always_comb begin
        phase_d     = phase_q;
        qcnt_d      = qcnt_q;
        stretch_d   = stretch_q;
        sel_d       = sel_q;
        req_d       = req_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        dout_d      = dout_q;
        doe_d       = doe_q;
        timeout_d   = 1'b0;

        if (ack_acc) begin
            req_d = 1'b0;
            if (!req_we_q) begin
                dout_d = RDATA;
                doe_d  = 1'b1;
            end
        end

        if (!last_clk) begin
            qcnt_d = qcnt_q + QW'(1);
        end else begin
            case (phase_q)
                P0: begin
                    phase_d = P1;
                    qcnt_d  = '0;
                end
                P1: begin
                    phase_d    = P2;
                    qcnt_d     = '0;
                    req_addr_d = A;
                    req_we_d   = ~RnW;
                    sel_d      = hit;
                    req_d      = hit && RnW;
                    // Preload the idle-bus value so an unanswered read returns FF.
                    if (hit && RnW) begin
                        dout_d = 8'hFF;
                    end
                end
                P2: begin
                    phase_d = P3;
                    qcnt_d  = '0;
                    if (sel_q && req_we_q) begin
                        req_wdata_d = DIn;
                        req_d       = 1'b1;
                    end
                end
                P3: begin
                    if (!pending) begin
                        phase_d   = P0;
                        qcnt_d    = '0;
                        stretch_d = '0;
                        sel_d     = 1'b0;
                        doe_d     = 1'b0;
                        req_d     = 1'b0;
                    end else if (STRETCH_EN) begin
                        // Hold E high; qcnt stays at its last value so every stretched CLK is a decision point.
                        stretch_d = stretch_nxt;
                        if (smax && !ack_acc) begin
                            req_d     = 1'b0;
                            timeout_d = 1'b1;
                            if (!req_we_q) begin
                                dout_d = 8'hFF;
                                doe_d  = 1'b1;
                            end
                        end
                    end else begin
                        phase_d   = P0;
                        qcnt_d    = '0;
                        stretch_d = '0;
                        sel_d     = 1'b0;
                        doe_d     = 1'b0;
                        req_d     = 1'b0;
                        timeout_d = 1'b1;
                        if (!req_we_q) begin
                            dout_d = 8'hFF;
                        end
                    end
                end
                default: begin
                    phase_d = P0;
                    qcnt_d  = '0;
                end
            endcase
        end

        e_d = (phase_d == P2) || (phase_d == P3);
        q_d = (phase_d == P1) || (phase_d == P2);
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            phase_q     <= P0;
            qcnt_q      <= '0;
            stretch_q   <= '0;
            e_q         <= 1'b0;
            q_q         <= 1'b0;
            sel_q       <= 1'b0;
            req_q       <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= 16'h0000;
            req_wdata_q <= 8'h00;
            dout_q      <= 8'hFF;
            doe_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            qcnt_q      <= qcnt_d;
            stretch_q   <= stretch_d;
            e_q         <= e_d;
            q_q         <= q_d;
            sel_q       <= sel_d;
            req_q       <= req_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
            timeout_q   <= timeout_d;
        end
    end

    assign E         = e_q;
    assign Q         = q_q;
    assign SEL       = sel_q;
    assign REQ       = req_q;
    assign REQ_WE    = req_we_q;
    assign REQ_ADDR  = req_addr_q;
    assign REQ_WDATA = req_wdata_q;
    assign DOut      = dout_q;
    assign DOE       = doe_q;
    assign TIMEOUT   = timeout_q;

endmodule
